// File: rtl/seq_detect_param_if.sv
// Serial detector bus: qualified input stream and controls in, match pulse and count out.
`timescale 1ns/1ps
interface seq_detect_param_if #(
    parameter int CNT_W = 8
) ();
    logic             en;
    logic             in;
    logic             ovl;
    logic             count_clr;
    logic             out;
    logic [CNT_W-1:0] match_count;

    modport master (
        output en, in, ovl, count_clr,
        input  out, match_count
    );

    modport slave (
        input  en, in, ovl, count_clr,
        output out, match_count
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with registered match pulse and saturating match counter.
// state | meaning
// k     | first k bits of PATTERN (MSB first) currently matched, k in 0..N-1
`timescale 1ns/1ps
module seq_detect_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1010,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    seq_detect_param_if.slave bus
);
    localparam int SW = $clog2(N + 1);

    if (N < 2 || N > 32) begin : g_bad_n
        $error("seq_detect_param: N must be in 2..32");
    end

    typedef logic [SW-1:0] state_t;

    // Entry (k*2 + bit) holds the longest PATTERN prefix that is a suffix of prefix(k) & bit.
    function automatic logic [2*N*SW-1:0] build_tbl();
        logic [2*N*SW-1:0] t;
        logic [N-1:0]      s;
        int                best;
        logic              ok;
        t = '0;
        for (int k = 0; k < N; k++) begin
            for (int b = 0; b < 2; b++) begin
                s = '0;
                for (int i = 0; i < k; i++) s[i] = PATTERN[N-1-i];
                s[k] = (b != 0);
                best = 0;
                for (int l = 1; l <= k + 1; l++) begin
                    ok = 1'b1;
                    for (int j = 0; j < l; j++)
                        if (s[k+1-l+j] != PATTERN[N-1-j]) ok = 1'b0;
                    if (ok) best = l;
                end
                t[(k*2+b)*SW +: SW] = SW'(best);
            end
        end
        return t;
    endfunction

    function automatic state_t build_border();
        int   best;
        logic ok;
        best = 0;
        for (int l = 1; l < N; l++) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++)
                if (PATTERN[N-1-j] != PATTERN[l-1-j]) ok = 1'b0;
            if (ok) best = l;
        end
        return SW'(best);
    endfunction

    localparam logic [2*N*SW-1:0] NXT_TBL = build_tbl();
    localparam state_t            BORDER  = build_border();
    localparam state_t            N_S     = SW'(N);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_nxt;
    state_t           k_nxt;
    logic             out_q, out_nxt;
    logic             match;
    logic [CNT_W-1:0] cnt_q;
    int               idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            out_q   <= out_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        out_nxt   = 1'b0;
        match     = 1'b0;
        idx       = 0;
        k_nxt     = '0;
        if (state_q >= N_S) begin
            state_nxt = '0;
        end else if (bus.en) begin
            idx   = (int'(state_q) * 2 + int'(bus.in)) * SW;
            k_nxt = NXT_TBL[idx +: SW];
            if (k_nxt == N_S) begin
                match     = 1'b1;
                out_nxt   = 1'b1;
                state_nxt = bus.ovl ? BORDER : '0;
            end else begin
                state_nxt = k_nxt;
            end
        end
    end

    // Clear wins over a coincident match; the pulse on out is unaffected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else if (bus.count_clr)
            cnt_q <= '0;
        else if (match && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
    end

    assign bus.out         = out_q;
    assign bus.match_count = cnt_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: three instances covering 1010, 110 and a 2-bit counter.
`timescale 1ns/1ps
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_detect_param_if #(.CNT_W(8)) if_a ();
    seq_detect_param_if #(.CNT_W(8)) if_b ();
    seq_detect_param_if #(.CNT_W(2)) if_c ();

    seq_detect_param #(.N(4), .PATTERN(4'b1010), .CNT_W(8)) u_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    seq_detect_param #(.N(3), .PATTERN(3'b110),  .CNT_W(8)) u_b (.clk(clk), .reset(reset), .bus(if_b.slave));
    seq_detect_param #(.N(4), .PATTERN(4'b1010), .CNT_W(2)) u_c (.clk(clk), .reset(reset), .bus(if_c.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_a(input logic b, input logic e, input logic exp_out, input string tag);
        @(negedge clk);
        if_a.in = b; if_a.en = e;
        @(posedge clk); #1;
        chk(tag, {31'd0, if_a.out}, {31'd0, exp_out});
    endtask

    task automatic send_b(input logic b, input logic exp_out, input string tag);
        @(negedge clk);
        if_b.in = b; if_b.en = 1'b1;
        @(posedge clk); #1;
        chk(tag, {31'd0, if_b.out}, {31'd0, exp_out});
    endtask

    task automatic send_c(input logic b, input logic clr, input logic exp_out, input string tag);
        @(negedge clk);
        if_c.in = b; if_c.en = 1'b1; if_c.count_clr = clr;
        @(posedge clk); #1;
        chk(tag, {31'd0, if_c.out}, {31'd0, exp_out});
    endtask

    task automatic idle_all();
        @(negedge clk);
        if_a.en = 1'b0; if_b.en = 1'b0; if_c.en = 1'b0;
        if_a.count_clr = 1'b0; if_b.count_clr = 1'b0; if_c.count_clr = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] stream;
        logic [9:0] exp_ovl0;
        logic [9:0] exp_ovl1;
        logic [3:0] pat4;
        logic [3:0] seq_b;
        logic [1:0] cnt_exp [5];

        stream   = 10'b1010101010;
        exp_ovl0 = 10'b0001000100;
        exp_ovl1 = 10'b0001010101;
        pat4     = 4'b1010;
        seq_b    = 4'b1110;
        cnt_exp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        if_a.en = 1'b0; if_a.in = 1'b0; if_a.ovl = 1'b0; if_a.count_clr = 1'b0;
        if_b.en = 1'b0; if_b.in = 1'b0; if_b.ovl = 1'b0; if_b.count_clr = 1'b0;
        if_c.en = 1'b0; if_c.in = 1'b0; if_c.ovl = 1'b1; if_c.count_clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_a", {31'd0, if_a.out}, 32'd0);
        chk("rst_cnt_a", {24'd0, if_a.match_count}, 32'd0);
        chk("rst_cnt_c", {30'd0, if_c.match_count}, 32'd0);
        @(negedge clk); reset = 1'b1;

        // Non-overlapping 1010 on 1010101010
        if_a.ovl = 1'b0;
        for (int i = 9; i >= 0; i--) send_a(stream[i], 1'b1, exp_ovl0[i], "t1_out");
        idle_all();
        chk("t1_cnt", {24'd0, if_a.match_count}, 32'd2);

        // Overlapping on the same stream
        pulse_reset();
        if_a.ovl = 1'b1;
        for (int i = 9; i >= 0; i--) send_a(stream[i], 1'b1, exp_ovl1[i], "t2_out");
        idle_all();
        chk("t2_cnt", {24'd0, if_a.match_count}, 32'd4);

        // 110 on 1110: retained "11" prefix
        for (int i = 3; i >= 0; i--) send_b(seq_b[i], (i == 0), "t3_out");
        idle_all();
        chk("t3_cnt", {24'd0, if_b.match_count}, 32'd1);

        // 1010 with three idle cycles between bits; in toggled while idle
        pulse_reset();
        if_a.ovl = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            send_a(pat4[i], 1'b1, (i == 0), "t4_bit");
            if (i != 0)
                for (int g = 0; g < 3; g++) send_a(~pat4[i-1], 1'b0, 1'b0, "t4_gap");
        end
        idle_all();
        chk("t4_cnt", {24'd0, if_a.match_count}, 32'd1);

        // Partial 101, reset mid-sequence, then 0 must not match
        send_a(1'b1, 1'b1, 1'b0, "t5_pre");
        send_a(1'b0, 1'b1, 1'b0, "t5_pre");
        send_a(1'b1, 1'b1, 1'b0, "t5_pre");
        @(negedge clk); if_a.en = 1'b0; reset = 1'b0;
        #1;
        chk("t5_rst_cnt", {24'd0, if_a.match_count}, 32'd0);
        chk("t5_rst_out", {31'd0, if_a.out}, 32'd0);
        @(negedge clk); reset = 1'b1;
        send_a(1'b0, 1'b1, 1'b0, "t5_after_rst");
        for (int i = 3; i >= 0; i--) send_a(pat4[i], 1'b1, (i == 0), "t5_match");
        idle_all();
        chk("t5_cnt", {24'd0, if_a.match_count}, 32'd1);

        // CNT_W=2 saturation, overlapping: matches after bits 4,6,8,10,12
        send_c(1'b1, 1'b0, 1'b0, "t6_lead");
        send_c(1'b0, 1'b0, 1'b0, "t6_lead");
        for (int m = 0; m < 5; m++) begin
            send_c(1'b1, 1'b0, 1'b0, "t6_mid");
            send_c(1'b0, 1'b0, 1'b1, "t6_hit");
            chk("t6_cnt", {30'd0, if_c.match_count}, {30'd0, cnt_exp[m]});
        end
        send_c(1'b1, 1'b0, 1'b0, "t6_clr_mid");
        send_c(1'b0, 1'b1, 1'b1, "t6_clr_hit");
        chk("t6_clr_cnt", {30'd0, if_c.match_count}, 32'd0);
        send_c(1'b1, 1'b0, 1'b0, "t6_post_mid");
        send_c(1'b0, 1'b0, 1'b1, "t6_post_hit");
        chk("t6_post_cnt", {30'd0, if_c.match_count}, 32'd1);
        idle_all();
        @(posedge clk); #1;
        chk("t6_idle_out", {31'd0, if_c.out}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
